homography_responder: RTL and testbench

//  Responder end of the homography query interface. Accepts one (query_x, query_y) per cycle while start=1.

---
 rtl/homography_responder.sv | 220 ++++++++++++++++++++++
 tb/tb_homography_responder.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/homography_responder.sv
// homography_responder: pipelined affine query responder with shadowed coefficients.
// Build macro HOMO_OOB_CNT_EN adds a saturating out-of-bounds result counter on oob_cnt.
module homography_responder #(
    parameter int SRC_W   = 640,
    parameter int SRC_H   = 480,
    parameter int FRAC    = 10,
    parameter int MEM_LAT = 2,
    parameter int ADDR_W  = 19
) (
    input  logic              clk_25,
    input  logic              rst,
    input  logic              start,
    input  logic [9:0]        query_x,
    input  logic [9:0]        query_y,
    output logic [9:0]        return_x,
    output logic [9:0]        return_y,
    output logic [4:0]        r,
    output logic [5:0]        g,
    output logic [4:0]        b,
    output logic              ready,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [15:0]       mem_rdata,
    input  logic              cfg_we,
    input  logic [2:0]        cfg_sel,
    input  logic [17:0]       cfg_data,
    input  logic              cfg_commit,
    output logic              busy,
    output logic [15:0]       oob_cnt
);
    // Handshake: start is a valid with no backpressure, one query per cycle; ready is a
    // one-cycle result valid per accepted query, in issue order. mem_rdata is sampled
    // MEM_LAT clock edges after the edge that launched mem_rd.

    localparam int CW = 18;
    localparam int PW = 29;
    localparam int SW = 31;
    localparam logic signed [CW-1:0] COEF_ONE = CW'(1 << FRAC);

    typedef enum logic [0:0] {C_IDLE, C_PEND} cfg_state_t;

    typedef struct packed {
        logic       v;
        logic       inb;
        logic [9:0] x;
        logic [9:0] y;
    } tag_t;

    cfg_state_t             cfg_state;
    logic signed [CW-1:0]   shadow_q   [6];
    logic signed [CW-1:0]   active_q   [6];
    logic signed [CW-1:0]   shadow_nxt [6];
    logic                   pipe_busy;
    logic                   apply;

    logic                   s1_v;
    logic [9:0]             s1_x, s1_y;
    logic signed [PW-1:0]   s1_ax, s1_by, s1_dx, s1_ey;
    logic signed [CW-1:0]   s1_c, s1_f;
    logic signed [10:0]     qx_s, qy_s;

    logic signed [SW-1:0]   sum_u, sum_v, u_full, v_full;
    logic                   uv_inb;

    logic                   s2_v, s2_inb;
    logic [9:0]             s2_x, s2_y;
    logic [ADDR_W-1:0]      s2_col, s2_row;

    tag_t                   tag_q [MEM_LAT];
    tag_t                   last;

    // A write in the same cycle as the copy must land, so the copy reads the post-write set.
    always_comb begin
        for (int i = 0; i < 6; i++) begin
            shadow_nxt[i] = shadow_q[i];
            if (cfg_we && cfg_sel == 3'(i)) begin
                shadow_nxt[i] = $signed(cfg_data);
            end
        end
    end

    assign apply = (cfg_state == C_PEND) && !start && !pipe_busy;

    always_ff @(posedge clk_25) begin
        if (rst) begin
            cfg_state <= C_IDLE;
            for (int i = 0; i < 6; i++) begin
                shadow_q[i] <= (i == 0 || i == 4) ? COEF_ONE : '0;
                active_q[i] <= (i == 0 || i == 4) ? COEF_ONE : '0;
            end
        end else begin
            for (int i = 0; i < 6; i++) begin
                shadow_q[i] <= shadow_nxt[i];
            end
            case (cfg_state)
                C_IDLE: begin
                    if (cfg_commit) cfg_state <= C_PEND;
                end
                C_PEND: begin
                    if (apply) begin
                        for (int i = 0; i < 6; i++) begin
                            active_q[i] <= shadow_nxt[i];
                        end
                        cfg_state <= C_IDLE;
                    end
                end
                default: cfg_state <= C_IDLE;
            endcase
        end
    end

    assign qx_s = $signed({1'b0, query_x});
    assign qy_s = $signed({1'b0, query_y});

    always_ff @(posedge clk_25) begin
        if (rst) begin
            s1_v <= 1'b0;
        end else begin
            s1_v <= start;
            if (start) begin
                s1_x  <= query_x;
                s1_y  <= query_y;
                s1_ax <= PW'(active_q[0]) * PW'(qx_s);
                s1_by <= PW'(active_q[1]) * PW'(qy_s);
                s1_c  <= active_q[2];
                s1_dx <= PW'(active_q[3]) * PW'(qx_s);
                s1_ey <= PW'(active_q[4]) * PW'(qy_s);
                s1_f  <= active_q[5];
            end
        end
    end

    always_comb begin
        sum_u  = SW'(s1_ax) + SW'(s1_by) + SW'(s1_c);
        sum_v  = SW'(s1_dx) + SW'(s1_ey) + SW'(s1_f);
        u_full = sum_u >>> FRAC;
        v_full = sum_v >>> FRAC;
        uv_inb = !u_full[SW-1] && (u_full < SW'(SRC_W)) &&
                 !v_full[SW-1] && (v_full < SW'(SRC_H));
    end

    always_ff @(posedge clk_25) begin
        if (rst) begin
            s2_v <= 1'b0;
        end else begin
            s2_v <= s1_v;
            if (s1_v) begin
                s2_inb <= uv_inb;
                s2_x   <= s1_x;
                s2_y   <= s1_y;
                s2_col <= ADDR_W'(u_full);
                s2_row <= ADDR_W'(v_full);
            end
        end
    end

    // Out-of-bounds queries and bubbles leave mem_addr at its last read address.
    always_ff @(posedge clk_25) begin
        if (rst) begin
            mem_rd   <= 1'b0;
            mem_addr <= '0;
            for (int i = 0; i < MEM_LAT; i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            mem_rd <= s2_v && s2_inb;
            if (s2_v && s2_inb) begin
                mem_addr <= s2_row * ADDR_W'(SRC_W) + s2_col;
            end
            tag_q[0] <= {s2_v, s2_inb, s2_x, s2_y};
            for (int i = 1; i < MEM_LAT; i++) begin
                tag_q[i] <= tag_q[i-1];
            end
        end
    end

    assign last = tag_q[MEM_LAT-1];

    always_ff @(posedge clk_25) begin
        if (rst) begin
            ready    <= 1'b0;
            return_x <= '0;
            return_y <= '0;
            r        <= '0;
            g        <= '0;
            b        <= '0;
        end else begin
            ready <= last.v;
            if (last.v) begin
                return_x <= last.x;
                return_y <= last.y;
                r        <= last.inb ? mem_rdata[15:11] : 5'd0;
                g        <= last.inb ? mem_rdata[10:5]  : 6'd0;
                b        <= last.inb ? mem_rdata[4:0]   : 5'd0;
            end
        end
    end

    always_comb begin
        pipe_busy = s1_v | s2_v;
        for (int i = 0; i < MEM_LAT; i++) begin
            pipe_busy = pipe_busy | tag_q[i].v;
        end
    end

    assign busy = pipe_busy | (cfg_state == C_PEND);

`ifdef HOMO_OOB_CNT_EN
    always_ff @(posedge clk_25) begin
        if (rst || apply) begin
            oob_cnt <= '0;
        end else if (last.v && !last.inb && oob_cnt != 16'hFFFF) begin
            oob_cnt <= oob_cnt + 16'd1;
        end
    end
`else
    assign oob_cnt = '0;
`endif

endmodule

// File: tb/tb_homography_responder.sv
// Bench for homography_responder: directed scenarios plus random queries, scored in issue order
// against an arithmetic reference of the affine map and a synthetic frame memory.
`timescale 1ns/1ps
module tb_homography_responder;
    localparam int FRAC    = 10;
    localparam int SRC_W   = 640;
    localparam int SRC_H   = 480;
    localparam int MEM_LAT = 2;
    localparam int ADDR_W  = 19;
    localparam int W       = 37;

    logic              clk_25, rst, start, ready, mem_rd, cfg_we, cfg_commit, busy;
    logic [9:0]        query_x, query_y, return_x, return_y;
    logic [4:0]        r, b;
    logic [5:0]        g;
    logic [ADDR_W-1:0] mem_addr;
    logic [15:0]       mem_rdata, oob_cnt;
    logic [2:0]        cfg_sel;
    logic [17:0]       cfg_data;

    homography_responder #(
        .SRC_W(SRC_W), .SRC_H(SRC_H), .FRAC(FRAC), .MEM_LAT(MEM_LAT), .ADDR_W(ADDR_W)
    ) dut (
        .clk_25(clk_25), .rst(rst), .start(start), .query_x(query_x), .query_y(query_y),
        .return_x(return_x), .return_y(return_y), .r(r), .g(g), .b(b), .ready(ready),
        .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_data(cfg_data), .cfg_commit(cfg_commit),
        .busy(busy), .oob_cnt(oob_cnt)
    );

    // clock / reset
    initial clk_25 = 1'b0;
    always #20 clk_25 = ~clk_25;

    // reference state and scoreboard
    int                model_shadow [6];
    int                model_active [6];
    bit                commit_pend;
    int                exp_oob;
    logic [W-1:0]      exp_q[$];
    logic [ADDR_W-1:0] exp_mem_q[$];
    int                n_cmp = 0;
    int                n_bad = 0;
    logic [31:0]       ready_hist = '0;

    function automatic logic [15:0] mem_data(input logic [ADDR_W-1:0] a);
        return a[15:0] ^ {a[18:16], a[18:16], 10'h2A5};
    endfunction

    always @(posedge clk_25) mem_rdata <= mem_rd ? mem_data(mem_addr) : 16'($urandom);

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 6; i++) begin
            model_shadow[i] = (i == 0 || i == 4) ? (1 << FRAC) : 0;
            model_active[i] = model_shadow[i];
        end
        commit_pend = 0;
        exp_oob     = 0;
    endtask

    task automatic model_push(input logic [9:0] x, input logic [9:0] y);
        longint su, sv, u, v, addr;
        bit inb;
        logic [15:0] rgb;
        su  = longint'(model_active[0]) * longint'(x) + longint'(model_active[1]) * longint'(y)
              + longint'(model_active[2]);
        sv  = longint'(model_active[3]) * longint'(x) + longint'(model_active[4]) * longint'(y)
              + longint'(model_active[5]);
        u   = su >>> FRAC;
        v   = sv >>> FRAC;
        inb = (u >= 0) && (u < SRC_W) && (v >= 0) && (v < SRC_H);
        rgb = 16'd0;
        if (inb) begin
            addr = v * SRC_W + u;
            exp_mem_q.push_back(ADDR_W'(addr));
            rgb = mem_data(ADDR_W'(addr));
        end
        exp_q.push_back({x, y, rgb, !inb});
    endtask

    // driver tasks
    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk_25); #1;
        end
    endtask

    task automatic issue_query(input logic [9:0] x, input logic [9:0] y);
        start = 1'b1; query_x = x; query_y = y;
        model_push(x, y);
        @(posedge clk_25); #1;
        start = 1'b0; query_x = 10'($urandom); query_y = 10'($urandom);
    endtask

    task automatic cfg_write(input int sel, input int val, input bit commit);
        cfg_we = 1'b1; cfg_sel = 3'(sel); cfg_data = 18'(val); cfg_commit = commit;
        if (sel < 6) model_shadow[sel] = val;
        if (commit) commit_pend = 1;
        @(posedge clk_25); #1;
        cfg_we = 1'b0; cfg_commit = 1'b0; cfg_data = 18'($urandom);
    endtask

    task automatic wait_idle();
        int cyc;
        cyc = 0;
        while (busy && cyc < 200) begin
            @(posedge clk_25); #1;
            cyc++;
        end
        check("busy_drain", busy, 0);
        idle(2);
        if (commit_pend) begin
            for (int i = 0; i < 6; i++) model_active[i] = model_shadow[i];
            exp_oob     = 0;
            commit_pend = 0;
        end
    endtask

    task automatic wait_drain();
        int cyc;
        cyc = 0;
        while (exp_q.size() != 0 && cyc < 100) begin
            @(posedge clk_25); #1;
            cyc++;
        end
        check("result_queue_empty", exp_q.size(), 0);
        check("mem_queue_empty", exp_mem_q.size(), 0);
    endtask

    // monitor: pops expectations whenever the DUT presents a result or a memory read
    always @(negedge clk_25) begin
        logic [W-1:0]      e;
        logic [ADDR_W-1:0] ea;
        ready_hist = {ready_hist[30:0], ready};
        if (!rst && ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL unexpected_ready: got ready=1 expected no result at %0t", $time);
            end else begin
                e = exp_q.pop_front();
                check("return_x", return_x, e[36:27]);
                check("return_y", return_y, e[26:17]);
                check("rgb", {r, g, b}, e[16:1]);
                if (e[0] && exp_oob < 65535) exp_oob++;
`ifdef HOMO_OOB_CNT_EN
                check("oob_cnt", oob_cnt, exp_oob);
`else
                check("oob_cnt", oob_cnt, 0);
`endif
            end
        end
        if (!rst && mem_rd) begin
            if (exp_mem_q.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL unexpected_mem_rd: got addr %0d expected no read at %0t", mem_addr, $time);
            end else begin
                ea = exp_mem_q.pop_front();
                check("mem_addr", mem_addr, ea);
            end
        end
    end

    initial begin
        int a, bb, c, d, e, f;
        rst = 1'b1; start = 1'b0; query_x = '0; query_y = '0;
        cfg_we = 1'b0; cfg_sel = '0; cfg_data = '0; cfg_commit = 1'b0;
        model_reset();
        idle(3);
        check("rst_ready", ready, 0);
        check("rst_mem_rd", mem_rd, 0);
        check("rst_busy", busy, 0);
        check("rst_return", {return_x, return_y}, 0);
        check("rst_rgb", {r, g, b}, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_oob_cnt", oob_cnt, 0);
        rst = 1'b0;
        idle(1);

        // identity mapping and exact latency
        issue_query(10'd3, 10'd2);
        idle(2);
        check("t1_mem_rd", mem_rd, 1);
        check("t1_mem_addr", mem_addr, 1283);
        idle(1);
        check("t1_ready_early", ready, 0);
        idle(1);
        check("t1_ready_lat5", ready, 1);
        idle(3);

        // negative offset forces an out-of-bounds result
        cfg_write(2, -(5 << FRAC), 1);
        check("t2_busy_pending", busy, 1);
        wait_idle();
        issue_query(10'd2, 10'd0);
        idle(8);

        // doubled x scale: one OOB, one in-bounds corner; write and commit share a cycle
        cfg_write(2, 0, 0);
        cfg_write(0, 2 << FRAC, 1);
        wait_idle();
        issue_query(10'd400, 10'd0);
        issue_query(10'd319, 10'd479);
        idle(8);

        // back-to-back burst, bubble, single
        cfg_write(0, 1 << FRAC, 1);
        wait_idle();
        for (int i = 0; i < 4; i++) issue_query(10'($urandom_range(0, 639)), 10'($urandom_range(0, 479)));
        idle(1);
        issue_query(10'($urandom_range(0, 639)), 10'($urandom_range(0, 479)));
        idle(5);
        check("t4_ready_pattern", ready_hist[6:0], 7'b0111101);
        idle(3);

        // commit during a stream is held off until the pipe drains
        for (int i = 0; i < 10; i++) begin
            if (i == 3) begin
                cfg_we = 1'b1; cfg_sel = 3'd2; cfg_data = 18'(10 << FRAC); cfg_commit = 1'b1;
                model_shadow[2] = 10 << FRAC;
                commit_pend = 1;
            end
            issue_query(10'($urandom_range(0, 620)), 10'($urandom_range(0, 479)));
            cfg_we = 1'b0; cfg_commit = 1'b0;
        end
        check("t5_busy_stream", busy, 1);
        wait_idle();
        issue_query(10'd5, 10'd5);
        idle(8);

        // randomized coefficients, queries and bubbles
        for (int it = 0; it < 300; it++) begin
            if ($urandom_range(0, 29) == 0) begin
                a  = $urandom_range(512, 2048);
                bb = int'($urandom_range(0, 512)) - 256;
                c  = int'($urandom_range(0, 204800)) - 102400;
                d  = int'($urandom_range(0, 512)) - 256;
                e  = $urandom_range(512, 2048);
                f  = int'($urandom_range(0, 204800)) - 102400;
                cfg_write(0, a, 0);
                cfg_write(1, bb, 0);
                cfg_write(6, int'($urandom_range(0, 4095)), 0);
                cfg_write(2, c, 0);
                cfg_write(3, d, 0);
                cfg_write(4, e, 0);
                cfg_write(5, f, 1);
                wait_idle();
            end else if ($urandom_range(0, 3) != 0) begin
                issue_query(10'($urandom), 10'($urandom));
            end else begin
                idle(1);
            end
        end
        wait_drain();
        idle(2);

        // reset with queries in flight drops them and restores identity
        cfg_write(2, 7 << FRAC, 1);
        wait_idle();
        for (int i = 0; i < 3; i++) issue_query(10'($urandom_range(0, 600)), 10'($urandom_range(0, 400)));
        rst = 1'b1;
        exp_q.delete();
        exp_mem_q.delete();
        model_reset();
        idle(2);
        rst = 1'b0;
        check("t6_busy_after_rst", busy, 0);
        idle(10);
        check("t6_no_ready", ready_hist[9:0], 0);
        issue_query(10'd7, 10'd9);
        idle(8);
        wait_drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
